// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - Function codes, FSM states and width default for the multiply sequencer.

package mul_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    STORE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_if.sv
// rtl/mul_if.sv - Control/operand bus between the sequencer and the shift-add multiplier datapath.

interface mul_if #(
  parameter int WIDTH = 32
);

  logic               mul_load;
  logic               mul_step;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_product;

  modport master (
    output mul_load,
    output mul_step,
    output mul_a,
    output mul_b,
    input  mul_product
  );

  modport slave (
    input  mul_load,
    input  mul_step,
    input  mul_a,
    input  mul_b,
    output mul_product
  );

endinterface

// File: rtl/mul_hilo_regs.sv
// rtl/mul_hilo_regs.sv - HI/LO product registers with optional negate on capture, and the dataOut read register.

module mul_hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture,
  input  logic               negate,
  input  logic [2*WIDTH-1:0] product,
  input  logic               rd_en,
  input  logic               rd_hi,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   data_out
);

  logic [2*WIDTH-1:0] product_fix;

  always_comb begin
    product_fix = negate ? -product : product;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      data_out <= '0;
    end else begin
      if (capture) begin
        {hi, lo} <= product_fix;
      end
      // reads only happen in IDLE, so hi/lo are never mid-update here
      if (rd_en) begin
        data_out <= rd_hi ? hi : lo;
      end
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - MULTU/MFHI/MFLO sequencer for an iterative shift-add multiplier; MUL_SIGNED_EN adds signed MULT.

module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  mul_if.master            mul
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             neg_q;
  logic             rd_done_q;
  logic             illegal_q;

  logic             is_mul;
  logic             is_read;
  logic             sign_req;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             idle_req;
  logic             rd_en;
  logic             store_cycle;

  always_comb begin
    is_read  = (Signal == MFHI) || (Signal == MFLO);
    is_mul   = (Signal == MULTU);
    sign_req = 1'b0;
    mag_a    = dataA;
    mag_b    = dataB;
`ifdef MUL_SIGNED_EN
    // most negative value wraps to itself, which is its correct unsigned magnitude
    if (Signal == MULT) begin
      is_mul   = 1'b1;
      sign_req = dataA[WIDTH-1] ^ dataB[WIDTH-1];
      if (dataA[WIDTH-1]) mag_a = -dataA;
      if (dataB[WIDTH-1]) mag_b = -dataB;
    end
`endif
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    idle_req     = (state == IDLE) && start;
    rd_en        = 1'b0;
    store_cycle  = 1'b0;
    mul.mul_load = 1'b0;
    mul.mul_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_mul) state_nxt = LOAD;
          rd_en = is_read;
        end
      end
      LOAD: begin
        mul.mul_load = 1'b1;
        state_nxt    = RUN;
      end
      RUN: begin
        mul.mul_step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = STORE;
      end
      STORE: begin
        store_cycle = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      neg_q     <= 1'b0;
      rd_done_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_done_q <= rd_en;
      illegal_q <= idle_req && !is_mul && !is_read;
      if (idle_req && is_mul) begin
        op_a  <= mag_a;
        op_b  <= mag_b;
        neg_q <= sign_req;
      end
      if (state == LOAD) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign mul.mul_a = op_a;
  assign mul.mul_b = op_b;
  assign done      = store_cycle | rd_done_q;
  assign illegal   = illegal_q;

  mul_hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk      (clk),
    .reset    (reset),
    .capture  (store_cycle),
    .negate   (neg_q),
    .product  (mul.mul_product),
    .rd_en    (rd_en),
    .rd_hi    (Signal == MFHI),
    .hi       (hi),
    .lo       (lo),
    .data_out (dataOut)
  );

endmodule
